// File: rtl/ramp_adc_controller.sv
// Ramp ADC sequencer: steps a DAC code upward and reports the first code at which the comparator drops.
// Optional RAMP_ADC_MAJORITY_EN: each decision becomes a 2-of-3 vote over three synchronized samples.
module ramp_adc_controller #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             comparator_output,
   output logic [WIDTH-1:0] duty_cycle,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             overrange
);

`ifdef RAMP_ADC_MAJORITY_EN
   localparam int M = 3;
`else
   localparam int M = 1;
`endif
   localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [1:0]       SAMPLE_LOAD = 2'(M - 1);
   localparam logic [WIDTH-1:0] FULL_SCALE  = '1;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    settleCnt_q;
   logic [1:0]       sampleCnt_q;
   logic [WIDTH-1:0] dutyCycle_q;
   logic [WIDTH-1:0] result_q;
   logic             busy_q;
   logic             resultValid_q;
   logic             overrange_q;
   logic             sync1_q;
   logic             sync2_q;
   logic             decision;

   // Reset to 1 so an idle comparator reads as "ramp still below input".
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= comparator_output;
         sync2_q <= sync1_q;
      end
   end

`ifdef RAMP_ADC_MAJORITY_EN
   logic [1:0] history_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         history_q <= 2'b11;
      end else if (state_q == SAMPLE) begin
         history_q <= {history_q[0], sync2_q};
      end
   end

   assign decision = (history_q[1] & history_q[0]) | (history_q[1] & sync2_q) | (history_q[0] & sync2_q);
`else
   assign decision = sync2_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         settleCnt_q   <= '0;
         sampleCnt_q   <= '0;
         dutyCycle_q   <= '0;
         result_q      <= '0;
         busy_q        <= 1'b0;
         resultValid_q <= 1'b0;
         overrange_q   <= 1'b0;
      end else begin
         resultValid_q <= 1'b0;
         if (state_q != IDLE && abort) begin
            state_q     <= IDLE;
            dutyCycle_q <= '0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !abort) begin
                     state_q     <= SETTLE;
                     dutyCycle_q <= '0;
                     settleCnt_q <= SETTLE_LOAD;
                     overrange_q <= 1'b0;
                     busy_q      <= 1'b1;
                  end
               end
               SETTLE: begin
                  if (settleCnt_q == '0) begin
                     sampleCnt_q <= SAMPLE_LOAD;
                     state_q     <= SAMPLE;
                  end else begin
                     settleCnt_q <= settleCnt_q - 1'b1;
                  end
               end
               SAMPLE: begin
                  // Full-scale is tested before incrementing so the code never wraps.
                  if (sampleCnt_q != '0) begin
                     sampleCnt_q <= sampleCnt_q - 1'b1;
                  end else if (!decision) begin
                     result_q      <= dutyCycle_q;
                     resultValid_q <= 1'b1;
                     state_q       <= DONE;
                  end else if (dutyCycle_q == FULL_SCALE) begin
                     result_q      <= FULL_SCALE;
                     overrange_q   <= 1'b1;
                     resultValid_q <= 1'b1;
                     state_q       <= DONE;
                  end else begin
                     dutyCycle_q <= dutyCycle_q + 1'b1;
                     settleCnt_q <= SETTLE_LOAD;
                     state_q     <= SETTLE;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign duty_cycle   = dutyCycle_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = resultValid_q;
   assign overrange    = overrange_q;

endmodule
